// File: rtl/cover_pkg.sv
// Shared types for the toggle-coverage collector: the global cover-point index
// type that leaves the block on the out_* handshake.
package cover_pkg;
  localparam int COVER_IDX_W = 64;
  typedef logic [COVER_IDX_W-1:0] cover_idx_t;
endpackage

// File: rtl/cover_lowest_set.sv
// Priority encoder: reports the position of the lowest set bit of a vector and
// whether any bit is set at all.
module cover_lowest_set #(
  parameter int WIDTH = 65,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] bits,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Scan high to low so the lowest set position is the last one written.
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (bits[i]) begin
        index = IDX_W'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// Collects per-point toggle hits, reports each newly covered point exactly once
// (lowest index first) and keeps a running count of covered points.
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int WIDTH       = 65,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 11747,
  localparam int CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       valid,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COVER_IDX_W-1:0] out_index,
  output logic [CNT_W-1:0]       covered_count,
  output logic                   all_covered
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("cover_toggle_collector: WIDTH must be 1..1024");
  end
  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
    $error("cover_toggle_collector: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] hit, pending;
  logic [WIDTH-1:0] hit_next, pending_next, pop_mask;
  logic [IDX_W-1:0] low_idx;
  logic             low_any;
  logic [CNT_W-1:0] count_next;

  cover_lowest_set #(.WIDTH(WIDTH)) u_lowest (
    .bits  (pending),
    .index (low_idx),
    .any   (low_any)
  );

  // Handshake: out_valid/out_index describe the lowest pending point; a transfer
  // happens on every rising edge where out_valid && out_ready, retiring exactly
  // that point. out_index only moves while stalled if a lower point arrives.
  assign out_valid   = low_any;
  assign out_index   = cover_idx_t'(COVER_INDEX) + cover_idx_t'(low_idx);
  assign all_covered = (covered_count == CNT_W'(WIDTH));

  always_comb begin
    pop_mask = '0;
    if (out_valid && out_ready) pop_mask[low_idx] = 1'b1;
  end

  // A popped point is already in hit, so (valid & ~hit) can never re-arm it.
  always_comb begin
    hit_next     = hit | valid;
    pending_next = (pending & ~pop_mask) | (valid & ~hit);
    count_next   = '0;
    for (int i = 0; i < WIDTH; i++) count_next = count_next + CNT_W'(hit_next[i]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit           <= '0;
      pending       <= '0;
      covered_count <= '0;
    end else if (clear) begin
      hit           <= '0;
      pending       <= '0;
      covered_count <= '0;
    end else begin
      hit           <= hit_next;
      pending       <= pending_next;
      covered_count <= count_next;
    end
  end

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Self-checking bench for cover_toggle_collector (WIDTH=65, COVER_INDEX=100):
// directed scenarios through an ordered expected queue plus a long random run.
module tb_cover_toggle_collector;
  localparam int WIDTH = 65;
  localparam int CIDX  = 100;
  localparam int CNT_W = 7;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] valid = '0;
  logic             clear = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [63:0]      out_index;
  logic [CNT_W-1:0] covered_count;
  logic             all_covered;

  cover_toggle_collector #(.WIDTH(WIDTH), .COVER_INDEX(CIDX), .COVER_TOTAL(11747)) dut (
    .clock         (clock),
    .reset         (reset),
    .valid         (valid),
    .clear         (clear),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_index     (out_index),
    .covered_count (covered_count),
    .all_covered   (all_covered)
  );

  // clock / reset
  always #5 clock = ~clock;

  int               n_tests = 0;
  int               n_fail  = 0;
  int               rep_count = 0;
  bit               use_q = 1'b0;
  logic [63:0]      exp_q[$];
  logic [WIDTH-1:0] m_hit  = '0;
  logic [WIDTH-1:0] m_pend = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [WIDTH-1:0] p);
    for (int i = 0; i < WIDTH; i++) if (p[i]) return i;
    return 0;
  endfunction

  function automatic int popc(input logic [WIDTH-1:0] p);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(p[i]);
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] onehot(input int i);
    logic [WIDTH-1:0] b = '0;
    b[i] = 1'b1;
    return b;
  endfunction

  // One clock cycle: check the state left by the previous edge, drive the inputs
  // for this cycle, score any transfer, then advance the reference model.
  task automatic cycle(input logic [WIDTH-1:0] v, input logic r, input logic c);
    logic [WIDTH-1:0] ones;
    ones = '1;
    @(negedge clock);
    check("covered_count", 64'(covered_count), 64'(popc(m_hit)));
    check("all_covered", 64'(all_covered), 64'(m_hit == ones));
    check("out_valid", 64'(out_valid), 64'(|m_pend));
    if (|m_pend) check("out_index", out_index, 64'(CIDX + lowest(m_pend)));
    valid = v;
    out_ready = r;
    clear = c;
    if (out_valid && r) begin
      rep_count++;
      if (use_q) begin
        if (exp_q.size() == 0) check("q_unexpected", out_index, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("q_order", out_index, exp_q.pop_front());
      end
    end
    if (c) begin
      m_hit = '0;
      m_pend = '0;
      rep_count = 0;
    end else begin
      if (r && |m_pend) m_pend[lowest(m_pend)] = 1'b0;
      m_pend = m_pend | (v & ~m_hit);
      m_hit = m_hit | v;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle('0, 1'b1, 1'b0);
    check("q_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] v;
    // reset state
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_index", out_index, 64'(CIDX));
    check("rst_count", 64'(covered_count), 64'd0);
    check("rst_all_covered", 64'(all_covered), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    use_q = 1'b1;

    // single point held several cycles: one report only
    for (int i = 0; i < 4; i++) cycle('0, 1'b1, 1'b0);
    exp_q.push_back(64'(CIDX + 3));
    for (int i = 0; i < 5; i++) cycle(onehot(3), 1'b1, 1'b0);
    drain(4);

    // everything at once with a stalled consumer, then full drain in order
    cycle('0, 1'b1, 1'b1);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(64'(CIDX + i));
    cycle('1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle('0, 1'b0, 1'b0);
    drain(WIDTH + 3);

    // lower point overtakes a stalled higher one
    cycle('0, 1'b1, 1'b1);
    exp_q.push_back(64'(CIDX + 2));
    exp_q.push_back(64'(CIDX + 10));
    cycle(onehot(10), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b0);
    cycle(onehot(2), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle('0, 1'b0, 1'b0);
    drain(4);

    // clear wins over a same-cycle hit of the top point
    cycle('0, 1'b1, 1'b1);
    cycle(onehot(64), 1'b1, 1'b1);
    cycle('0, 1'b1, 1'b0);
    exp_q.push_back(64'(CIDX + 64));
    cycle(onehot(64), 1'b1, 1'b0);
    drain(4);

    // reset mid-drain discards pending reports
    cycle('0, 1'b1, 1'b1);
    v = '0;
    for (int i = 0; i < 20; i++) v[i] = 1'b1;
    cycle(v, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_count", 64'(covered_count), 64'd0);
    check("mid_rst_out_index", out_index, 64'(CIDX));
    m_hit = '0;
    m_pend = '0;
    @(negedge clock);
    reset = 1'b1;
    exp_q.push_back(64'(CIDX + 5));
    cycle(onehot(5), 1'b1, 1'b0);
    drain(4);

    // random hits, random back-pressure, occasional clear
    use_q = 1'b0;
    cycle('0, 1'b1, 1'b1);
    for (int n = 0; n < 10000; n++) begin
      v = '0;
      if ($urandom_range(0, 7) == 0) v[$urandom_range(0, WIDTH - 1)] = 1'b1;
      if ($urandom_range(0, 31) == 0) v[$urandom_range(0, WIDTH - 1)] = 1'b1;
      cycle(v, 1'(($urandom_range(0, 2)) != 0 ? 1 : 0), 1'($urandom_range(0, 599) == 0 ? 1 : 0));
    end
    for (int i = 0; i < WIDTH + 5; i++) cycle('0, 1'b1, 1'b0);
    check("rand_reports", 64'(rep_count), 64'(popc(m_hit)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cover_toggle_collector.md
COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 65, number of toggle cover points (1..1024).
REQ-002 SHALL have parameter COVER_INDEX, default 0, global index of cover point 0.
REQ-003 SHALL have parameter COVER_TOTAL, default 11747, total cover points in design; used only in elaboration check COVER_INDEX+WIDTH <= COVER_TOTAL.
REQ-004 SHALL have port clock, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port valid, input, WIDTH, per-point toggle hit strobes, sampled every cycle.
REQ-007 SHALL have port clear, input, 1, synchronous clear of all collected state.
REQ-008 SHALL have port out_valid, output, 1, a newly covered index is presented.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts out_index.
REQ-010 SHALL have port out_index, output, 64, global index (COVER_INDEX + local bit).
REQ-011 SHALL have port covered_count, output, clog2(WIDTH+1), number of points hit since reset/clear.
REQ-012 SHALL have port all_covered, output, 1, high when covered_count == WIDTH.

Function
REQ-013 SHALL keep a WIDTH-bit sticky register hit: hit_next = hit | valid.
REQ-014 SHALL keep a WIDTH-bit pending register: pending_next = (pending & ~pop_mask) | (valid & ~hit).
REQ-015 A point SHALL be reported at most once between resets/clears, however many cycles its valid bit is high.
REQ-016 out_valid SHALL equal |pending; out_index SHALL be COVER_INDEX + lowest set bit position of pending, zero-extended to 64 bits.
REQ-017 Latency: valid[i] high in cycle t with hit[i]=0 SHALL give pending[i]=1 and a possible out_valid in cycle t+1.
REQ-018 Pop: when out_valid && out_ready, pop_mask SHALL be a one-hot of the presented bit, cleared on the next edge; exactly one index per cycle.
REQ-019 out_index SHALL stay stable while out_valid && !out_ready unless a lower-numbered bit becomes pending (lowest-first priority, no starvation since entries never re-arm).
REQ-020 Simultaneous pop and new hits SHALL both take effect in the same edge; a popped bit is never re-inserted.
REQ-021 covered_count SHALL be registered popcount(hit_next); it saturates naturally at WIDTH.
REQ-022 clear SHALL zero hit, pending and covered_count on the next edge, with priority over valid and pop in that cycle; valid in the clear cycle is ignored.
REQ-023 With out_ready held low, pending SHALL accumulate without loss (capacity WIDTH, no overflow possible).

Reset
REQ-024 On reset low, hit, pending, covered_count SHALL clear to 0 asynchronously; out_valid=0, out_index=COVER_INDEX, all_covered=0.
REQ-025 Reset mid-drain SHALL discard all pending reports; after release, collection restarts from empty.

Structure
REQ-026 Package cover_pkg SHALL hold COVER_IDX_W=64 and typedef cover_idx_t (64-bit unsigned).
REQ-027 Lowest-set-bit logic SHALL be sub-module cover_lowest_set (parameter WIDTH; outputs index and any).
REQ-028 Block SHALL be synthesisable; no DPI inside it; simulation-only consumers attach to the out_* handshake.

Verification (WIDTH=65, COVER_INDEX=100)
REQ-029 valid[3] high cycles 5-9, out_ready=1 -> exactly one out_index=103 at cycle 6; covered_count=1 from cycle 6.
REQ-030 valid=all-ones one cycle, out_ready=0 for 10 cycles then 1 -> indices 100..164 in order, one per cycle, 65 transfers, all_covered=1 one cycle after the hit.
REQ-031 pending {10}, out_ready=0, then valid[2] pulse -> out_index moves 110 to 102; both later delivered, 102 first.
REQ-032 valid[64] and clear same cycle -> no report, covered_count=0; valid[64] next cycle -> out_index=164.
REQ-033 reset asserted with 20 pending, released -> out_valid=0, covered_count=0; re-hit of a prior point reported again.
REQ-034 random valid and out_ready 10k cycles -> each index reported once, set equals OR of valid, covered_count matches model.
